muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_div_step.sv | 28 ++
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative signed multiply/divide unit.
package muldiv_pkg;

   localparam int ITER = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_t;

   typedef logic [5:0] cnt_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring shift-subtract step on unsigned remainder/quotient magnitudes.
module muldiv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   // Remainder stays below the divisor, so the top bit of w_diff is a clean borrow flag.
   always_comb begin
      w_shift = {i_rem, i_quo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, i_dvs};
      if (w_diff[WIDTH]) begin
         o_rem = w_shift[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b0};
      end else begin
         o_rem = w_diff[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Shared iterative signed multiply (Booth radix-2) / divide (restoring) unit.
// Define MULDIV_FAST_ZERO_EN to short-circuit multiplies with a zero operand.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             mult_end,
   output logic             div_end,
   output logic             div_by_zero
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam cnt_t             LAST = cnt_t'(ITER - 1);

   state_t           r_state, w_state;
   cnt_t             r_cnt, w_cnt;
   logic [WIDTH-1:0] r_acc, w_acc, r_q, w_q, r_m, w_m, r_hi, w_hi, r_lo, w_lo;
   logic             r_qm1, w_qm1, r_is_div, w_is_div, r_dz, w_dz;
   logic             r_neg_q, w_neg_q, r_neg_r, w_neg_r;
   logic             r_mult_end, w_mult_end, r_div_end, w_div_end, r_dbz, w_dbz;

   logic [WIDTH:0]   w_acc_ext, w_m_ext, w_sum;
   logic [WIDTH-1:0] w_a_mag, w_b_mag, w_div_rem, w_div_quo;

   // Booth add/subtract in WIDTH+1 bits so negating the most negative multiplicand cannot overflow.
   always_comb begin
      w_acc_ext = {r_acc[WIDTH-1], r_acc};
      w_m_ext   = {r_m[WIDTH-1], r_m};
      case ({r_q[0], r_qm1})
         2'b01:   w_sum = w_acc_ext + w_m_ext;
         2'b10:   w_sum = w_acc_ext - w_m_ext;
         default: w_sum = w_acc_ext;
      endcase
   end

   assign w_a_mag = a[WIDTH-1] ? (~a + ONE) : a;
   assign w_b_mag = b[WIDTH-1] ? (~b + ONE) : b;

   muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem (r_acc),
      .i_quo (r_q),
      .i_dvs (r_m),
      .o_rem (w_div_rem),
      .o_quo (w_div_quo)
   );

   // Next-state and next-register values for the whole datapath.
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_acc      = r_acc;
      w_q        = r_q;
      w_qm1      = r_qm1;
      w_m        = r_m;
      w_is_div   = r_is_div;
      w_dz       = r_dz;
      w_neg_q    = r_neg_q;
      w_neg_r    = r_neg_r;
      w_hi       = r_hi;
      w_lo       = r_lo;
      w_mult_end = 1'b0;
      w_div_end  = 1'b0;
      w_dbz      = 1'b0;
      case (r_state)
         IDLE: begin
            if (mult_start) begin
               w_m      = a;
               w_q      = b;
               w_acc    = ZERO;
               w_qm1    = 1'b0;
               w_cnt    = 6'd0;
               w_is_div = 1'b0;
               w_dz     = 1'b0;
`ifdef MULDIV_FAST_ZERO_EN
               if ((a == ZERO) || (b == ZERO)) begin
                  w_q     = ZERO;
                  w_state = FIN;
               end else begin
                  w_state = MUL;
               end
`else
               w_state  = MUL;
`endif
            end else if (div_start) begin
               w_is_div = 1'b1;
               w_acc    = ZERO;
               w_q      = w_a_mag;
               w_m      = w_b_mag;
               w_neg_q  = a[WIDTH-1] ^ b[WIDTH-1];
               w_neg_r  = a[WIDTH-1];
               w_cnt    = 6'd0;
               if (b == ZERO) begin
                  w_dz    = 1'b1;
                  w_state = FIN;
               end else begin
                  w_dz    = 1'b0;
                  w_state = DIV;
               end
            end else begin
               w_state = IDLE;
            end
         end
         MUL: begin
            w_acc = w_sum[WIDTH:1];
            w_q   = {w_sum[0], r_q[WIDTH-1:1]};
            w_qm1 = r_q[0];
            w_cnt = r_cnt + 6'd1;
            if (r_cnt == LAST) begin
               w_state = FIN;
            end else begin
               w_state = MUL;
            end
         end
         DIV: begin
            w_acc = w_div_rem;
            w_q   = w_div_quo;
            w_cnt = r_cnt + 6'd1;
            if (r_cnt == LAST) begin
               w_state = FIN;
            end else begin
               w_state = DIV;
            end
         end
         FIN: begin
            w_state = IDLE;
            if (r_dz) begin
               w_div_end = 1'b1;
               w_dbz     = 1'b1;
            end else if (r_is_div) begin
               w_lo      = r_neg_q ? (~r_q + ONE) : r_q;
               w_hi      = r_neg_r ? (~r_acc + ONE) : r_acc;
               w_div_end = 1'b1;
            end else begin
               w_hi       = r_acc;
               w_lo       = r_q;
               w_mult_end = 1'b1;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= 6'd0;
         r_acc      <= ZERO;
         r_q        <= ZERO;
         r_qm1      <= 1'b0;
         r_m        <= ZERO;
         r_is_div   <= 1'b0;
         r_dz       <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_hi       <= ZERO;
         r_lo       <= ZERO;
         r_mult_end <= 1'b0;
         r_div_end  <= 1'b0;
         r_dbz      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_acc      <= w_acc;
         r_q        <= w_q;
         r_qm1      <= w_qm1;
         r_m        <= w_m;
         r_is_div   <= w_is_div;
         r_dz       <= w_dz;
         r_neg_q    <= w_neg_q;
         r_neg_r    <= w_neg_r;
         r_hi       <= w_hi;
         r_lo       <= w_lo;
         r_mult_end <= w_mult_end;
         r_div_end  <= w_div_end;
         r_dbz      <= w_dbz;
      end
   end

   assign hi          = r_hi;
   assign lo          = r_lo;
   assign mult_end    = r_mult_end;
   assign div_end     = r_div_end;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: transaction-level reference model plus literal expectations.
module tb_muldiv_unit;

   localparam int F_NONE = 0;
   localparam int F_MUL  = 1;
   localparam int F_DIV  = 2;
   localparam int F_DZ   = 3;
`ifdef MULDIV_FAST_ZERO_EN
   localparam int FZ_LAT = 1;
`else
   localparam int FZ_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mult_start = 1'b0;
   logic        div_start = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [31:0] hi, lo;
   logic        mult_end, div_end, div_by_zero;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   int          edge_n = 0;
   int          m_end_edge = 0;
   int          m_kind = 0;
   int          m_fire = 0;
   bit          m_busy = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] m_res = 64'd0;

   muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .mult_start  (mult_start),
      .div_start   (div_start),
      .a           (a),
      .b           (b),
      .hi          (hi),
      .lo          (lo),
      .mult_end    (mult_end),
      .div_end     (div_end),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: {hi, lo} as signed 64-bit math defines them.
   function automatic logic [63:0] calc(input bit is_div, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (!is_div) begin
         q = sx * sy;
         return q;
      end else if (y == 32'd0) begin
         return 64'd0;
      end else begin
         q = sx / sy;
         r = sx % sy;
         return {r[31:0], q[31:0]};
      end
   endfunction

   // Transaction model: accept a start when idle, deliver its result a fixed number of edges later.
   always @(posedge clk) begin
      edge_n <= edge_n + 1;
      if (rst) begin
         m_busy <= 1'b0;
         m_fire <= F_NONE;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
      end else begin
         if (m_busy && (edge_n == m_end_edge)) begin
            m_busy <= 1'b0;
            m_fire <= m_kind;
            if (m_kind != F_DZ) begin
               m_hi <= m_res[63:32];
               m_lo <= m_res[31:0];
            end
         end else begin
            m_fire <= F_NONE;
         end
         if (!m_busy && mult_start) begin
            m_kind     <= F_MUL;
            m_res      <= calc(1'b0, a, b);
            m_end_edge <= edge_n + (((a == 32'd0) || (b == 32'd0)) ? FZ_LAT : 33);
            m_busy     <= 1'b1;
         end else if (!m_busy && div_start) begin
            m_kind     <= (b == 32'd0) ? F_DZ : F_DIV;
            m_res      <= calc(1'b1, a, b);
            m_end_edge <= edge_n + ((b == 32'd0) ? 1 : 33);
            m_busy     <= 1'b1;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_mult_end", mult_end, m_fire == F_MUL);
         check("cyc_div_end", div_end, (m_fire == F_DIV) || (m_fire == F_DZ));
         check("cyc_div_by_zero", div_by_zero, m_fire == F_DZ);
         check("cyc_hi", hi, m_hi);
         check("cyc_lo", lo, m_lo);
      end
   end

   task automatic do_op(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                        input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit exp_dz, input string name);
      int k;
      @(negedge clk);
      a = av;
      b = bv;
      if (is_div) div_start = 1'b1;
      else mult_start = 1'b1;
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      a = $urandom;
      b = $urandom;
      k = 0;
      while (!(mult_end || div_end) && (k < 100)) begin
         @(negedge clk);
         k++;
      end
      check({name, "_latency"}, 64'(k), 64'(exp_lat));
      check({name, "_end"}, is_div ? div_end : mult_end, 1'b1);
      check({name, "_dbz"}, div_by_zero, exp_dz);
      check({name, "_hi"}, hi, exp_hi);
      check({name, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int k, nm, nd, tm;
      repeat (3) @(negedge clk);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_ends", {mult_end, div_end, div_by_zero}, 3'b000);
      rst = 1'b0;
      chk_en = 1'b1;

      do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
      do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'd0, 1'b0, "mul_min_min");
      do_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, "mul_max_max");
      do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd0, 32'd1, 1'b0, "mul_m1_m1");
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
      do_op(1'b1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, "div_by_zero");
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, "div_min_m1");
      do_op(1'b1, 32'd100, 32'hFFFF_FFF9, 33, 32'd2, 32'hFFFF_FFF2, 1'b0, "div_100_m7");
      do_op(1'b0, 32'd0, 32'd12345, FZ_LAT, 32'd0, 32'd0, 1'b0, "mul_zero");

      // Simultaneous starts, then a stray div_start while the multiply runs.
      @(negedge clk);
      a = 32'd6;
      b = 32'd7;
      mult_start = 1'b1;
      div_start  = 1'b1;
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      k = 0; nm = 0; nd = 0; tm = 0;
      while (k < 60) begin
         div_start = (k == 4);
         @(negedge clk);
         k++;
         if (mult_end) begin
            nm++;
            if (nm == 1) tm = k;
         end
         if (div_end) nd++;
      end
      div_start = 1'b0;
      check("both_mult_end_count", 64'(nm), 64'd1);
      check("both_div_end_count", 64'(nd), 64'd0);
      check("both_latency", 64'(tm), 64'd33);
      check("both_hi", hi, 32'd0);
      check("both_lo", lo, 32'd42);

      // Reset ten edges into a divide.
      @(negedge clk);
      a = 32'd1000;
      b = 32'd3;
      div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_end) nd++;
      end
      check("rst_no_div_end", 64'(nd), 64'd0);
      do_op(1'b1, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, "div_100_7");

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
